// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// PS2_BREAK_DECODE_EN (optional) enables 0xF0 break-prefix decoding in the top.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int         PS2_DATA_BITS  = 8;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 lines into Clock and flags clk_kb falling edges.
module ps2_sync_edge
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clk_kb,
    input  logic data_kb,
    output logic data_s,
    output logic fe
);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   clk_prev;

    // Reset to the idle-high line level so leaving reset never fakes an edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_sr   <= '1;
            data_sr  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], clk_kb};
            data_sr  <= {data_sr[SYNC_STAGES-2:0], data_kb};
            clk_prev <= clk_sr[SYNC_STAGES-1];
        end
    end

    assign data_s = data_sr[SYNC_STAGES-1];
    assign fe     = clk_prev & ~clk_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame deserialiser with parity/stop/timeout checking.
// Define PS2_BREAK_DECODE_EN to fold 0xF0 prefixes into oKeyReleased.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       clk_kb,
    input  logic       data_kb,
    output logic [7:0] oScanCode,
    output logic       oScanValid,
    output logic       oKeyReleased,
    output logic       oFrameError
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    BIT_LAST = 4'(PS2_DATA_BITS - 1);

    logic          data_s;
    logic          fe;
    ps2_state_t    state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          good, bad, tmo;
    logic          emit, rel_d;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .Clock  (Clock),
        .Reset  (Reset),
        .clk_kb (clk_kb),
        .data_kb(data_kb),
        .data_s (data_s),
        .fe     (fe)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        good    = 1'b0;
        bad     = 1'b0;
        tmo     = 1'b0;
        if (fe || state_q == IDLE)
            tcnt_d = '0;
        else if (tcnt_q == TMO_LAST)
            tcnt_d = tcnt_q;
        else
            tcnt_d = tcnt_q + 1'b1;
        // A falling edge always takes priority over an expiring timeout.
        if (fe) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d = DATA;
                        bit_d   = '0;
                        shift_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    if (data_s && (^shift_q ^ par_q))
                        good = 1'b1;
                    else
                        bad = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tcnt_q == TMO_LAST) begin
            tmo     = 1'b1;
            state_d = IDLE;
            shift_d = '0;
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    logic brk_q;

    always_ff @(posedge Clock) begin
        if (Reset)
            brk_q <= 1'b0;
        else if (bad || tmo)
            brk_q <= 1'b0;
        else if (good)
            brk_q <= (shift_q == PS2_BREAK_CODE);
    end

    assign emit  = good && (shift_q != PS2_BREAK_CODE);
    assign rel_d = brk_q;
`else
    assign emit  = good;
    assign rel_d = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oScanCode    <= 8'h00;
            oScanValid   <= 1'b0;
            oKeyReleased <= 1'b0;
            oFrameError  <= 1'b0;
        end else begin
            oScanValid   <= emit;
            oKeyReleased <= emit & rel_d;
            oFrameError  <= bad | tmo;
            if (emit)
                oScanCode <= shift_q;
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed self-checking bench for ps2_frame_receiver.
// Expectations follow PS2_BREAK_DECODE_EN when it is defined for the build.
module tb_ps2_frame_receiver;

    localparam int TMO = 200;

    logic       Clock   = 1'b0;
    logic       Reset   = 1'b1;
    logic       clk_kb  = 1'b1;
    logic       data_kb = 1'b1;
    logic [7:0] oScanCode;
    logic       oScanValid;
    logic       oKeyReleased;
    logic       oFrameError;

    int nchk = 0;
    int nerr = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    int longp = 0;
    logic pv = 1'b0;
    logic pe = 1'b0;
    logic [7:0] codes [0:63];
    logic       rels  [0:63];
    int v0, e0;

    ps2_frame_receiver #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .clk_kb      (clk_kb),
        .data_kb     (data_kb),
        .oScanCode   (oScanCode),
        .oScanValid  (oScanValid),
        .oKeyReleased(oKeyReleased),
        .oFrameError (oFrameError)
    );

    always #5 Clock = ~Clock;

    // Strobe recorder, sampled mid-cycle away from the active edge.
    always @(negedge Clock) begin
        if (oScanValid === 1'b1) begin
            codes[vcnt[5:0]] <= oScanCode;
            rels[vcnt[5:0]]  <= oKeyReleased;
            vcnt <= vcnt + 1;
        end
        if (oFrameError === 1'b1)
            ecnt <= ecnt + 1;
        if (oScanValid === 1'b1 && oFrameError === 1'b1)
            both <= both + 1;
        if ((oScanValid === 1'b1 && pv) || (oFrameError === 1'b1 && pe))
            longp <= longp + 1;
        pv <= (oScanValid === 1'b1);
        pe <= (oFrameError === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic send_bit(input logic b);
        data_kb = b;
        cyc(4);
        clk_kb = 1'b0;
        cyc(8);
        clk_kb = 1'b1;
        cyc(4);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        data_kb = 1'b1;
        cyc(20);
    endtask

    task automatic snap();
        v0 = vcnt;
        e0 = ecnt;
    endtask

    initial begin
        cyc(10);
        Reset = 1'b0;
        cyc(5);
        chk("reset_code", 32'(oScanCode), 32'h00);
        chk("reset_valid", 32'(oScanValid), 32'h0);
        chk("reset_rel", 32'(oKeyReleased), 32'h0);
        chk("reset_err", 32'(oFrameError), 32'h0);
        chk("reset_nvalid", 32'(vcnt), 32'd0);
        chk("reset_nerr", 32'(ecnt), 32'd0);

        // 0x22 with correct odd parity
        snap();
        send_frame(8'h22, 1'b1, 1'b1);
        chk("good22_nvalid", 32'(vcnt - v0), 32'd1);
        chk("good22_nerr", 32'(ecnt - e0), 32'd0);
        chk("good22_code", 32'(codes[v0]), 32'h22);
        chk("good22_rel", 32'(rels[v0]), 32'h0);
        chk("good22_hold", 32'(oScanCode), 32'h22);

        // parity error
        snap();
        send_frame(8'h22, 1'b0, 1'b1);
        chk("par_nerr", 32'(ecnt - e0), 32'd1);
        chk("par_nvalid", 32'(vcnt - v0), 32'd0);
        chk("par_code", 32'(oScanCode), 32'h22);

        // bad stop bit, then clean 0x1C
        snap();
        send_frame(8'h22, 1'b1, 1'b0);
        chk("stop_nerr", 32'(ecnt - e0), 32'd1);
        chk("stop_nvalid", 32'(vcnt - v0), 32'd0);
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("after_stop_nvalid", 32'(vcnt - v0), 32'd1);
        chk("after_stop_code", 32'(codes[v0]), 32'h1C);
        chk("after_stop_nerr", 32'(ecnt - e0), 32'd0);

        // timeout after four data bits
        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        data_kb = 1'b1;
        cyc(TMO + 50);
        chk("tmo_nerr", 32'(ecnt - e0), 32'd1);
        chk("tmo_nvalid", 32'(vcnt - v0), 32'd0);
        chk("tmo_code", 32'(oScanCode), 32'h1C);
        snap();
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("after_tmo_nvalid", 32'(vcnt - v0), 32'd1);
        chk("after_tmo_code", 32'(codes[v0]), 32'h5A);
        chk("after_tmo_nerr", 32'(ecnt - e0), 32'd0);

        // reset in the middle of a frame
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        Reset = 1'b1;
        cyc(3);
        Reset = 1'b0;
        data_kb = 1'b1;
        cyc(TMO + 20);
        chk("midrst_code", 32'(oScanCode), 32'h00);
        chk("midrst_nvalid", 32'(vcnt - v0), 32'd0);
        chk("midrst_nerr", 32'(ecnt - e0), 32'd0);
        snap();
        send_frame(8'h22, 1'b1, 1'b1);
        chk("after_rst_nvalid", 32'(vcnt - v0), 32'd1);
        chk("after_rst_code", 32'(codes[v0]), 32'h22);

        // break prefix followed by 0x22
        snap();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        chk("brk_nerr", 32'(ecnt - e0), 32'd0);
`ifdef PS2_BREAK_DECODE_EN
        chk("brk_nvalid", 32'(vcnt - v0), 32'd1);
        chk("brk_code", 32'(codes[v0]), 32'h22);
        chk("brk_rel", 32'(rels[v0]), 32'h1);
`else
        chk("brk_nvalid", 32'(vcnt - v0), 32'd2);
        chk("brk_code0", 32'(codes[v0]), 32'hF0);
        chk("brk_rel0", 32'(rels[v0]), 32'h0);
        chk("brk_code1", 32'(codes[v0 + 1]), 32'h22);
        chk("brk_rel1", 32'(rels[v0 + 1]), 32'h0);
`endif
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("post_brk_nvalid", 32'(vcnt - v0), 32'd1);
        chk("post_brk_code", 32'(codes[v0]), 32'h1C);
        chk("post_brk_rel", 32'(rels[v0]), 32'h0);

        chk("strobe_overlap", 32'(both), 32'd0);
        chk("strobe_width", 32'(longp), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
